// File: rtl/cex_pkg.sv
// rtl/cex_pkg.sv - state encoding and default geometry for the counterexample replayer
package cex_pkg;

  localparam int CEX_IN_W  = 2;
  localparam int CEX_OUT_W = 4;
  localparam int CEX_DEPTH = 16;
  localparam int CEX_LAT   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } cex_state_e;

endpackage

// File: rtl/cex_trace_mem.sv
// rtl/cex_trace_mem.sv - trace vector storage, registered write and combinational read
module cex_trace_mem
  import cex_pkg::*;
#(
  parameter int IN_W  = CEX_IN_W,
  parameter int DEPTH = CEX_DEPTH,
  parameter int AW    = $clog2(CEX_DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [IN_W-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [IN_W-1:0] rd_data
);

  logic [IN_W-1:0] mem_q [DEPTH];
  logic [IN_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // Contents survive reset; only the fill count decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/cex_replayer.sv
// rtl/cex_replayer.sv - loads a counterexample trace, replays it into two circuits, reports first divergence
module cex_replayer
  import cex_pkg::*;
#(
  parameter int IN_W  = CEX_IN_W,
  parameter int OUT_W = CEX_OUT_W,
  parameter int DEPTH = CEX_DEPTH,
  parameter int LAT   = CEX_LAT
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [IN_W-1:0]          s_data,
  input  logic                     s_last,
  input  logic                     start,
  input  logic                     clear,
  output logic [IN_W-1:0]          DUT_IN,
  input  logic [OUT_W-1:0]         OUT_A,
  input  logic [OUT_W-1:0]         OUT_B,
  output logic                     busy,
  output logic                     done,
  output logic                     mismatch,
  output logic [$clog2(DEPTH)-1:0] mismatch_idx,
  output logic                     trunc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  cex_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    drain_q, drain_d;
  logic          mismatch_q, mismatch_d;
  logic          trunc_q, trunc_d;
  logic [AW-1:0] idx_q, idx_d;

  logic          beat, last_rd, run_v, tag_v, diff_hit;
  logic [AW-1:0] tag_idx;
  logic [IN_W-1:0] rd_data;

  assign beat     = s_ready && s_valid && !clear;
  assign last_rd  = (CW'(rd_ptr_q) + CW'(1)) == count_q;
  assign run_v    = state_q == ST_RUN;
  assign diff_hit = (state_q == ST_RUN || state_q == ST_DRAIN) && tag_v &&
                    (OUT_A != OUT_B) && !mismatch_q;

  cex_trace_mem #(
    .IN_W  (IN_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (beat),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (s_data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Tag pipeline lines each driven index up with the circuits' response.
  generate
    if (LAT == 0) begin : g_nolat
      assign tag_v   = run_v;
      assign tag_idx = rd_ptr_q;
    end else begin : g_pipe
      logic [LAT-1:0]    pv_q, pv_d;
      logic [LAT*AW-1:0] pi_q, pi_d;

      always_comb begin
        pv_d         = pv_q << 1;
        pi_d         = pi_q << AW;
        pv_d[0]      = run_v;
        pi_d[AW-1:0] = rd_ptr_q;
        if (clear) pv_d = '0;
      end

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          pv_q <= '0;
          pi_q <= '0;
        end else begin
          pv_q <= pv_d;
          pi_q <= pi_d;
        end
      end

      assign tag_v   = pv_q[LAT-1];
      assign tag_idx = pi_q[LAT*AW-1 -: AW];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      drain_q    <= '0;
      mismatch_q <= 1'b0;
      trunc_q    <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      drain_q    <= drain_d;
      mismatch_q <= mismatch_d;
      trunc_q    <= trunc_d;
      idx_q      <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    drain_d    = drain_q;
    mismatch_d = mismatch_q;
    trunc_d    = trunc_q;
    idx_d      = idx_q;
    if (clear) begin
      state_d    = ST_IDLE;
      count_d    = '0;
      rd_ptr_d   = '0;
      drain_d    = '0;
      mismatch_d = 1'b0;
      trunc_d    = 1'b0;
      idx_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (beat) begin
            count_d = count_q + CW'(1);
            if (s_last) begin
              state_d = ST_ARMED;
            end else if (count_q == CW'(DEPTH - 1)) begin
              state_d = ST_ARMED;
              trunc_d = 1'b1;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end
        ST_ARMED: begin
          if (start) begin
            state_d  = ST_RUN;
            rd_ptr_d = '0;
          end
        end
        ST_RUN: begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (last_rd) begin
            state_d = (LAT == 0) ? ST_DONE : ST_DRAIN;
            drain_d = '0;
          end
        end
        ST_DRAIN: begin
          if (drain_q == 3'(LAT - 1)) state_d = ST_DONE;
          else                        drain_d = drain_q + 3'd1;
        end
        default: ;
      endcase
      // First divergence wins and cuts the replay short.
      if (diff_hit) begin
        mismatch_d = 1'b1;
        idx_d      = tag_idx;
        state_d    = ST_DONE;
      end
    end
  end

  always_comb begin
    s_ready      = (state_q == ST_IDLE || state_q == ST_LOAD) && (count_q < CW'(DEPTH));
    busy         = state_q == ST_RUN || state_q == ST_DRAIN;
    done         = state_q == ST_DONE;
    DUT_IN       = (state_q == ST_RUN) ? rd_data : '0;
    mismatch     = mismatch_q;
    mismatch_idx = idx_q;
    trunc        = trunc_q;
  end

endmodule

// File: tb/tb_cex_replayer.sv
// tb/tb_cex_replayer.sv - randomized bench for cex_replayer at LAT=1 and LAT=0 against a trace-level model
module tb_cex_replayer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST_N = 1'b1;
  logic       s_valid = 1'b0, s_last = 1'b0, start = 1'b0, clear = 1'b0;
  logic [1:0] s_data = '0;

  logic       s_ready1, busy1, done1, mis1, trunc1;
  logic       s_ready0, busy0, done0, mis0, trunc0;
  logic [3:0] idx1, idx0;
  logic [1:0] din1, din0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic       a0, b0;

  logic       b_all = 1'b0, bad_en = 1'b0;
  logic [1:0] bad_val = '0;
  logic [1:0] tr [16];

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic nand2(input logic [1:0] x);
    return ~(x[1] & x[0]);
  endfunction

  function automatic logic inject(input logic [1:0] x);
    return b_all || (bad_en && x == bad_val);
  endfunction

  // Circuit A is a NAND; circuit B is the same NAND, inverted on selected vectors.
  always @(posedge CLK) begin
    a1 <= nand2(din1);
    b1 <= nand2(din1) ^ inject(din1);
  end
  assign a0 = nand2(din0);
  assign b0 = nand2(din0) ^ inject(din0);

  cex_replayer #(.IN_W(2), .OUT_W(1), .DEPTH(16), .LAT(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
    .s_last(s_last), .start(start), .clear(clear), .DUT_IN(din1), .OUT_A(a1), .OUT_B(b1),
    .busy(busy1), .done(done1), .mismatch(mis1), .mismatch_idx(idx1), .trunc(trunc1)
  );

  cex_replayer #(.IN_W(2), .OUT_W(1), .DEPTH(16), .LAT(0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .s_last(s_last), .start(start), .clear(clear), .DUT_IN(din0), .OUT_A(a0), .OUT_B(b0),
    .busy(busy0), .done(done0), .mismatch(mis0), .mismatch_idx(idx0), .trunc(trunc0)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_s_ready"}, {s_ready1, s_ready0}, 2'b11);
    check_eq({tag, "_busy"},    {busy1, busy0},       2'b00);
    check_eq({tag, "_done"},    {done1, done0},       2'b00);
    check_eq({tag, "_mis"},     {mis1, mis0},         2'b00);
    check_eq({tag, "_idx"},     {idx1, idx0},         8'h00);
    check_eq({tag, "_trunc"},   {trunc1, trunc0},     2'b00);
    check_eq({tag, "_din"},     {din1, din0},         4'h0);
  endtask

  function automatic int exp_din(input int c, input int dc, input int len);
    if (c < dc && c < len) return int'(tr[c]);
    return 0;
  endfunction

  task automatic load(input int len, input bit last);
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        start   = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check_eq("start_ignored_busy", {busy1, busy0}, 2'b00);
      end
      s_valid = 1'b1;
      s_data  = tr[i];
      s_last  = last && (i == len - 1);
      check_eq("s_ready_load", {s_ready1, s_ready0}, 2'b11);
      @(negedge CLK);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_eq("armed_s_ready", {s_ready1, s_ready0}, 2'b00);
    check_eq("armed_trunc",   {trunc1, trunc0},     last ? 2'b00 : 2'b11);
    check_eq("armed_busy",    {busy1, busy0, done1, done0}, 4'h0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
  endtask

  task automatic run_case(input int len, input bit last);
    int k, dc1, dc0;
    k = -1;
    for (int i = 0; i < len; i++)
      if (k < 0 && inject(tr[i])) k = i;
    dc1 = (k >= 0) ? k + 2 : len + 1;
    dc0 = (k >= 0) ? k + 1 : len;
    load(len, last);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int c = 0; c < len + 4; c++) begin
      check_eq("din_lat1",  din1,  exp_din(c, dc1, len));
      check_eq("busy_lat1", busy1, c < dc1);
      check_eq("done_lat1", done1, c >= dc1);
      check_eq("din_lat0",  din0,  exp_din(c, dc0, len));
      check_eq("busy_lat0", busy0, c < dc0);
      check_eq("done_lat0", done0, c >= dc0);
      @(negedge CLK);
    end
    check_eq("mis_lat1",   mis1,   k >= 0);
    check_eq("idx_lat1",   idx1,   (k >= 0) ? k : 0);
    check_eq("mis_lat0",   mis0,   k >= 0);
    check_eq("idx_lat0",   idx0,   (k >= 0) ? k : 0);
    check_eq("done_trunc", {trunc1, trunc0}, last ? 2'b00 : 2'b11);
    check_eq("done_s_ready", {s_ready1, s_ready0}, 2'b00);
    pulse_clear();
    check_idle("after_clear");
  endtask

  initial begin
    #1 RST_N = 1'b0;
    #1 check_idle("reset_async");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_idle("reset");

    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check_eq("start_in_idle_busy", {busy1, busy0}, 2'b00);

    for (int i = 0; i < 4; i++) tr[i] = 2'(i);
    run_case(4, 1'b1);
    b_all = 1'b1;
    run_case(4, 1'b1);
    b_all = 1'b0; bad_en = 1'b1; bad_val = 2'd3;
    run_case(4, 1'b1);
    bad_en = 1'b0;
    for (int i = 0; i < 16; i++) tr[i] = 2'($urandom_range(0, 3));
    run_case(16, 1'b0);

    for (int t = 0; t < 24; t++) begin
      int len;
      bit last;
      len = $urandom_range(1, 16);
      last = (len < 16) || ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 16; i++) tr[i] = 2'($urandom_range(0, 3));
      b_all   = ($urandom_range(0, 7) == 0);
      bad_en  = ($urandom_range(0, 1) == 1);
      bad_val = 2'($urandom_range(0, 3));
      run_case(len, last);
    end

    b_all = 1'b0; bad_en = 1'b0;
    tr[0] = 2'd1; tr[1] = 2'd2; tr[2] = 2'd3; tr[3] = 2'd1; tr[4] = 2'd2; tr[5] = 2'd0;
    load(6, 1'b1);
    start = 1'b1; clear = 1'b1;
    @(negedge CLK);
    start = 1'b0; clear = 1'b0;
    check_idle("clear_beats_start");

    load(6, 1'b1);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    check_eq("run_din_before_reset", {din1, din0}, 4'hF);
    #1 RST_N = 1'b0;
    #1;
    check_eq("rst_mid_din",  {din1, din0},   4'h0);
    check_eq("rst_mid_busy", {busy1, busy0}, 2'b00);
    check_eq("rst_mid_mis",  {mis1, mis0},   2'b00);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check_idle("after_mid_reset");

    load(6, 1'b1);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    check_eq("run_busy_before_clear", {busy1, busy0}, 2'b11);
    pulse_clear();
    check_idle("clear_in_run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cex_replayer.md
CEX_REPLAYER -- requirements
Module: cex_replayer

Interface
REQ-001 Parameter IN_W, default 2: width of the DUT input vector.
REQ-002 Parameter OUT_W, default 4: width of the DUT output vector.
REQ-003 Parameter DEPTH, default 16: maximum trace length in vectors.
REQ-004 Parameter LAT, default 1: cycles from driving DUT_IN to the matching response on OUT_A/OUT_B (0 to 7).
REQ-005 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 RST_N  in  1  reset, asynchronous, active-low.
REQ-007 s_valid  in  1  trace beat valid.
REQ-008 s_ready  out  1  trace beat accepted when s_valid and s_ready are both 1.
REQ-009 s_data  in  IN_W  one input vector of a counterexample trace.
REQ-010 s_last  in  1  marks the final beat of a trace.
REQ-011 start  in  1  one-cycle pulse that begins replay.
REQ-012 clear  in  1  one-cycle pulse that discards the trace and results.
REQ-013 DUT_IN  out  IN_W  vector driven to both circuits under comparison.
REQ-014 OUT_A, OUT_B  in  OUT_W  outputs of circuit A and circuit B.
REQ-015 busy  out  1  high in RUN and DRAIN.
REQ-016 done  out  1  high in DONE.
REQ-017 mismatch  out  1  sticky flag: an output difference was found.
REQ-018 mismatch_idx  out  clog2(DEPTH)  trace index of the first differing vector.
REQ-019 trunc  out  1  trace reached DEPTH without s_last.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD, ARMED, RUN, DRAIN and DONE.
REQ-021 IDLE/LOAD: s_ready=1 while count<DEPTH; each handshake writes s_data at address count and increments count; the first beat moves IDLE->LOAD.
REQ-022 A handshake with s_last=1 SHALL move the FSM to ARMED; the DEPTH-th beat without s_last SHALL move it to ARMED, set trunc=1, and drop s_ready.
REQ-023 s_ready SHALL be 0 in ARMED, RUN, DRAIN and DONE; s_valid SHALL be ignored in those states.
REQ-024 start SHALL be honoured only in ARMED (ARMED->RUN, rd_ptr=0); in any other state it SHALL have no effect.
REQ-025 RUN: DUT_IN=mem[rd_ptr] each cycle; rd_ptr increments by 1; after index count-1 is driven, the FSM SHALL go to DRAIN.
REQ-026 Outside RUN, DUT_IN SHALL be all-zero.
REQ-027 A LAT-deep valid/index pipeline SHALL tag each driven vector; OUT_A!=OUT_B SHALL be sampled only when the tag emerging from the pipeline is valid.
REQ-028 On the first tagged difference, the block SHALL set mismatch=1, latch mismatch_idx, and move to DONE in the next cycle; further differences SHALL be ignored.
REQ-029 DRAIN SHALL last exactly LAT cycles and then go to DONE; with LAT=0 the comparison SHALL be combinational in the same cycle and DRAIN SHALL be skipped.
REQ-030 DONE SHALL hold all results until clear; clear in any state except RUN/DRAIN SHALL return to IDLE with count=0, mismatch=0, trunc=0, mismatch_idx=0.
REQ-031 clear in RUN or DRAIN SHALL abort the replay to IDLE with the same zeroing.
REQ-032 clear and start in the same cycle: clear SHALL win.

Reset
REQ-033 With RST_N=0 the block SHALL be in IDLE with count=0, rd_ptr=0, the pipeline invalid, DUT_IN=0, s_ready=1, busy=0, done=0, mismatch=0, mismatch_idx=0 and trunc=0, regardless of CLK.
REQ-034 Reset asserted mid-replay SHALL abort the replay immediately; trace memory contents need not be cleared.

Structure
REQ-035 The package cex_pkg SHALL hold the FSM state enum and the default values of IN_W, OUT_W, DEPTH and LAT.
REQ-036 The trace storage SHALL be the sub-module cex_trace_mem (DEPTH x IN_W, 1 write port, 1 read port, registered write and combinational read).

Verification
REQ-037 IN_W=2, OUT_W=1, LAT=1; A = registered NAND, B = registered AND+NOT; trace 00,01,10,11 with last on 11; start -> done=1, mismatch=0 after 4+1 cycles.
REQ-038 Same trace with B = registered NAND+NOT -> mismatch=1, mismatch_idx=0 (1 vs 0), done one cycle after detection.
REQ-039 Load 16 beats with s_last never set -> s_ready=0 after the 16th beat, trunc=1, state ARMED; start replays all 16.
REQ-040 Pulse start in IDLE and in LOAD -> no effect, busy stays 0; then a clear pulse in DONE -> all outputs return to their reset values.
REQ-041 Assert RST_N=0 during RUN at rd_ptr=2 -> DUT_IN=0, busy=0 and mismatch=0 immediately, without a clock edge.
REQ-042 LAT=0 with A!=B only on vector index 3 -> mismatch_idx=3, and DRAIN is never entered.
